// File: rtl/pwr_ctrl_seq.sv
// Power-control sequencer for the clock-mux / LFSR power domains.
// Drives isolation, retention strobes and power switches in order.
module pwr_ctrl_seq #(
    parameter int ISO_CYC     = 2,
    parameter int SAVE_CYC    = 1,
    parameter int SW_CYC      = 4,
    parameter int RESTORE_CYC = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pd_req,
    input  logic       pu_req,
    output logic       ck_mx_sw_ctr,
    output logic       lfsr_sw_ctr,
    output logic       iso1,
    output logic       iso2,
    output logic       save_lfsr,
    output logic       restore_lfsr,
    output logic       busy,
    output logic       done,
    output logic [1:0] pwr_state
);

    typedef enum logic [3:0] {
        S_ON,
        S_ISO_DN,
        S_SAVE,
        S_LFSR_OFF,
        S_CM_OFF,
        S_OFF,
        S_CM_ON,
        S_LFSR_ON,
        S_RESTORE,
        S_ISO_UP
    } state_t;

    // Counter reload values: a phase of N cycles starts at N-1.
    localparam logic [CNT_W-1:0] L_ISO  = CNT_W'(ISO_CYC - 1);
    localparam logic [CNT_W-1:0] L_SAVE = CNT_W'(SAVE_CYC - 1);
    localparam logic [CNT_W-1:0] L_SW   = CNT_W'(SW_CYC - 1);
    localparam logic [CNT_W-1:0] L_RST  = CNT_W'(RESTORE_CYC - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_zero;

    logic             w_ck;
    logic             w_lf;
    logic             w_iso1;
    logic             w_iso2;
    logic             w_save;
    logic             w_rest;
    logic             w_busy;
    logic             w_done;
    logic [1:0]       w_ps;

    assign w_cnt_zero = (r_cnt == '0);

    // State and phase wait-counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_ON;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: stable states sample requests, phases exit at count 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? '0 : (r_cnt - C_ONE);
        unique case (r_state)
            S_ON: begin
                w_cnt_nxt = '0;
                if (pd_req) begin
                    w_state_nxt = S_ISO_DN;
                    w_cnt_nxt   = L_ISO;
                end
            end
            S_ISO_DN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_SAVE;
                    w_cnt_nxt   = L_SAVE;
                end
            end
            S_SAVE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_LFSR_OFF;
                    w_cnt_nxt   = L_SW;
                end
            end
            S_LFSR_OFF: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_CM_OFF;
                    w_cnt_nxt   = L_SW;
                end
            end
            S_CM_OFF: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_OFF;
                    w_cnt_nxt   = '0;
                end
            end
            S_OFF: begin
                w_cnt_nxt = '0;
                if (pu_req) begin
                    w_state_nxt = S_CM_ON;
                    w_cnt_nxt   = L_SW;
                end
            end
            S_CM_ON: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_LFSR_ON;
                    w_cnt_nxt   = L_SW;
                end
            end
            S_LFSR_ON: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_RESTORE;
                    w_cnt_nxt   = L_RST;
                end
            end
            S_RESTORE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_ISO_UP;
                    w_cnt_nxt   = L_ISO;
                end
            end
            S_ISO_UP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_ON;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_ON;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode of the upcoming state so every output is registered.
    always_comb begin
        w_ck   = 1'b1;
        w_lf   = 1'b1;
        w_iso1 = 1'b1;
        w_iso2 = 1'b1;
        w_save = 1'b0;
        w_rest = 1'b0;
        w_busy = 1'b1;
        w_ps   = 2'b01;
        unique case (w_state_nxt)
            S_ON: begin
                w_iso1 = 1'b0;
                w_iso2 = 1'b0;
                w_busy = 1'b0;
                w_ps   = 2'b00;
            end
            S_ISO_DN: begin
                w_ps = 2'b01;
            end
            S_SAVE: begin
                w_save = 1'b1;
            end
            S_LFSR_OFF: begin
                w_lf = 1'b0;
            end
            S_CM_OFF: begin
                w_lf = 1'b0;
                w_ck = 1'b0;
            end
            S_OFF: begin
                w_lf   = 1'b0;
                w_ck   = 1'b0;
                w_busy = 1'b0;
                w_ps   = 2'b10;
            end
            S_CM_ON: begin
                w_lf = 1'b0;
                w_ps = 2'b11;
            end
            S_LFSR_ON: begin
                w_ps = 2'b11;
            end
            S_RESTORE: begin
                w_rest = 1'b1;
                w_ps   = 2'b11;
            end
            S_ISO_UP: begin
                w_ps = 2'b11;
            end
            default: begin
                w_iso1 = 1'b0;
                w_iso2 = 1'b0;
                w_busy = 1'b0;
                w_ps   = 2'b00;
            end
        endcase
    end

    // A sequence completes when its last phase hands over to a stable state.
    assign w_done = ((r_state == S_CM_OFF) && (w_state_nxt == S_OFF)) ||
                    ((r_state == S_ISO_UP) && (w_state_nxt == S_ON));

    // Output registers; reset leaves both domains powered and de-isolated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ck_mx_sw_ctr <= 1'b1;
            lfsr_sw_ctr  <= 1'b1;
            iso1         <= 1'b0;
            iso2         <= 1'b0;
            save_lfsr    <= 1'b0;
            restore_lfsr <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pwr_state    <= 2'b00;
        end else begin
            ck_mx_sw_ctr <= w_ck;
            lfsr_sw_ctr  <= w_lf;
            iso1         <= w_iso1;
            iso2         <= w_iso2;
            save_lfsr    <= w_save;
            restore_lfsr <= w_rest;
            busy         <= w_busy;
            done         <= w_done;
            pwr_state    <= w_ps;
        end
    end

endmodule

// File: doc/pwr_ctrl_seq.md
Name: pwr_ctrl_seq

Overview:
- Power-control sequencer that drives the power-control inputs of the clock-mux/LFSR top: ck_mx_sw_ctr, lfsr_sw_ctr, iso1, iso2, save_lfsr and restore_lfsr.
- It is the initiator side of the power-control interface, i.e. the power-management unit.
- On a power-down request it isolates, saves LFSR state, then switches off the LFSR domain and then the clock-mux domain.
- On a power-up request it runs the reverse sequence.

Parameters:
- ISO_CYC, 2, cycles isolation is held before save (down) and after restore (up); legal range 1..255.
- SAVE_CYC, 1, width of save_lfsr pulse in cycles; 1..255.
- SW_CYC, 4, settle cycles after each power-switch transition; 1..255.
- RESTORE_CYC, 1, width of restore_lfsr pulse in cycles; 1..255.
- CNT_W, 8, phase wait-counter width.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- pd_req  input  1  power-down request (level); sampled only in state ON.
- pu_req  input  1  power-up request (level); sampled only in state OFF.
- ck_mx_sw_ctr  output  1  clock-mux domain switch; 1 = powered.
- lfsr_sw_ctr  output  1  LFSR domain switch; 1 = powered.
- iso1  output  1  isolation of clock-mux domain outputs; 1 = isolated.
- iso2  output  1  isolation of LFSR domain outputs; 1 = isolated.
- save_lfsr  output  1  retention save strobe.
- restore_lfsr  output  1  retention restore strobe.
- busy  output  1  high while a sequence is in progress.
- done  output  1  one-cycle pulse when a sequence completes.
- pwr_state  output  2  00 ON, 01 GOING_DOWN, 10 OFF, 11 GOING_UP.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clk edge), including mid-sequence: enter ON immediately. Outputs: ck_mx_sw_ctr=1, lfsr_sw_ctr=1, iso1=iso2=0, save_lfsr=restore_lfsr=0, busy=0, done=0, pwr_state=00. Wait counter cleared.
- FSM states: ON, ISO_DN, SAVE, LFSR_OFF, CM_OFF, OFF, CM_ON, LFSR_ON, RESTORE, ISO_UP.
- One CNT_W-bit down-counter is loaded on each phase entry with (phase length - 1). The phase exits when the counter is 0, so each phase lasts exactly its parameter cycles.
- Power-down sequence, with pd_req=1 sampled in ON at edge T:
  - ISO_DN, from T+1: iso1=iso2=1; lasts ISO_CYC cycles.
  - SAVE: save_lfsr=1 for SAVE_CYC cycles; isolation held.
  - LFSR_OFF: save_lfsr=0, lfsr_sw_ctr=0; lasts SW_CYC cycles.
  - CM_OFF: ck_mx_sw_ctr=0; lasts SW_CYC cycles.
  - OFF: entered at T+1+ISO_CYC+SAVE_CYC+2*SW_CYC, with done=1 for that single cycle.
- Power-up sequence, with pu_req=1 sampled in OFF at edge T:
  - CM_ON, from T+1: ck_mx_sw_ctr=1; lasts SW_CYC cycles.
  - LFSR_ON: lfsr_sw_ctr=1; lasts SW_CYC cycles.
  - RESTORE: restore_lfsr=1 for RESTORE_CYC cycles.
  - ISO_UP: restore_lfsr=0, isolation still held; lasts ISO_CYC cycles.
  - ON: entered with iso1=iso2=0 and a done pulse, at T+1+2*SW_CYC+RESTORE_CYC+ISO_CYC.
- In OFF: iso1=iso2=1, both switches 0, strobes 0.
- busy=1 and pwr_state=01/11 in every transitional state. busy=0 in ON and OFF.
- Requests are ignored while busy; there is no abort and no queuing.
- A request that is still high when the sequence ends is re-evaluated in the stable state. Only the meaningful request acts: pd_req in ON, pu_req in OFF.
- pd_req and pu_req both high in ON → power-down. Both high in OFF → power-up. pd_req in OFF and pu_req in ON are no-ops.
- Invariants, never violated:
  - save_lfsr and restore_lfsr are never high together.
  - save_lfsr and restore_lfsr are high only with iso2=1 and, for restore, lfsr_sw_ctr=1.
  - A switch never changes state while the corresponding iso is 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release → pwr_state=00, sw_ctr both 1, iso 0, busy 0, strobes 0.
- Power-down with defaults: pd_req at T → iso1/iso2=1 at T+1; save_lfsr=1 only at T+3; lfsr_sw_ctr=0 at T+4; ck_mx_sw_ctr=0 at T+8; done pulse with pwr_state=10 at T+12.
- Power-up from OFF with defaults: pu_req at T → ck_mx_sw_ctr=1 at T+1; lfsr_sw_ctr=1 at T+5; restore_lfsr=1 only at T+9; iso=0, done, pwr_state=00 at T+12.
- Ignored requests: pu_req pulsed mid power-down, and pu_req in ON → sequence timing unchanged, no state change. pd_req and pu_req both high in ON → power-down.
- Reset mid-sequence: rst=0 during SAVE → next edge outputs at ON reset values, save_lfsr=0, no done pulse.
- Parameter corner: ISO_CYC=SAVE_CYC=SW_CYC=RESTORE_CYC=1 → down completes at T+5, up at T+5; invariants hold (checked by assertions in all tests).
